vmx_mac_engine: RTL and testbench
=================================

# vmx_mac_engine

Matrix-vector multiply compute core of the mm_vmx accelerator. It sits directly downstream of the mm_vmx AXI4-Lite slave register file, which decodes CPU writes into operand-load strobes and a start pulse and reads results back through a registered read port. The core holds a DIM×DIM signed matrix and a DIM-element signed vector, computes y = M·x with one multiply-accumulate per cycle, and stores DIM 32-bit sign-extended results.

## Interface
Parameters:
- DIM, 4: matrix/vector dimension; power of 2, ≥2.
- DW, 8: signed operand element width; 2*DW+$clog2(DIM) ≤ 32.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = matrix, 1 = vector.
- wr_addr  in  $clog2(DIM*DIM)  matrix index row*DIM+col, or vector index.
- wr_data  in  DW  signed operand.
- start  in  1  start pulse.
- err_clr  in  1  clears err.
- rd_addr  in  $clog2(DIM)  result index.
- rd_data  out  32  result[rd_addr], registered.
- busy  out  1  computation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol-violation flag.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN. Row counter r and column counter c are cleared and the accumulator is cleared.
- RUN: each cycle acc += M[r][c]*x[c]. Multiplication is signed DW×DW → 2*DW. The accumulator is ACC_W = 2*DW+$clog2(DIM) bits, so overflow is impossible.
- On the cycle with c==DIM-1: result[r] ← sign-extend(acc + product) to 32, the accumulator clears, c→0, r++.
- On the cycle with r==DIM-1 and c==DIM-1: FSM → DONE.
- DONE lasts one cycle, then returns to IDLE. A start in DONE is accepted exactly as a start in IDLE.
- Operand writes are accepted only in IDLE/DONE. A wr_sel=1 write with wr_addr ≥ DIM is dropped silently, with no err.
- A write or start while in RUN is dropped and sets err. err_clr clears err; err_clr and a new violation in the same cycle leave err=1.
- Results are retained until overwritten by the next run. Reads during RUN return the currently stored value, so rows already finished show new data.
- Reset at any time, including mid-run:
  - FSM → IDLE, counters and accumulator → 0.
  - All matrix, vector and result registers → 0.
  - No done pulse is issued.

## Timing
- Reset values: rd_data=0, busy=0, done=0, err=0.
- start sampled at edge k → busy=1 from cycle k+1 through k+DIM*DIM.
- done=1 and busy=0 in cycle k+DIM*DIM+1. Latency is 17 cycles for the default DIM=4.
- result[r] is visible in storage after the edge that ends cycle k+(r+1)*DIM.
- rd_data has 1-cycle latency: rd_addr sampled at edge n appears after edge n.
- Read/write collision on the same row in the same cycle returns the old value (read-before-write).
- Operand write at edge n is usable by a start sampled at edge n+1 or later.

## Structure
- Package vmx_pkg:
  - state_t enum (IDLE, RUN, DONE).
  - Default DIM/DW localparams.
  - acc_w(DIM, DW) function.
  - RES_W=32.
- Sub-module vmx_mac: signed multiply plus ACC_W accumulator with clr and en inputs. It outputs the sum including the current product, which is used for writeback.
- Top level: FSM, counters, operand/result register arrays, err logic, read register.

## Test plan
- Reset, then idle 10 cycles → rd_data=0, busy=0, done=0, err=0 throughout.
- Identity M, x=[1,2,3,4], start at edge k → busy for 16 cycles, done at k+17, reads return 1,2,3,4.
- All M=-128, x=-128 → every result 0x00010000. Then all M=127, x=-128 → every result 0xFFFF0200.
- During RUN: start pulse and a matrix write → err=1, results identical to the undisturbed run. err_clr → err=0.
- Deassert ARESETN at cycle 8 of a run → busy drops immediately, no done, all reads 0. Reload operands and rerun → correct results.
- Start asserted in the DONE cycle → second run begins, busy rises next cycle, done after 17 more cycles.

Source files
------------

// File: rtl/vmx_pkg.sv
// Shared types, default sizing and accumulator-width helper for the mm_vmx
// matrix-vector compute core.
package vmx_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   localparam int unsigned DefaultDim = 4;
   localparam int unsigned DefaultDw  = 8;
   localparam int unsigned RES_W      = 32;

   // Wide enough that DIM products of two DW-bit signed values cannot overflow.
   function automatic int unsigned acc_w(input int unsigned dim, input int unsigned dw);
      return 2 * dw + $clog2(dim);
   endfunction

endpackage

// File: rtl/vmx_mac.sv
// Signed multiply-accumulate slice; sum_o includes the current product so the
// caller can write back the finished dot product in the same cycle.
module vmx_mac
   import vmx_pkg::*;
#(
   parameter int unsigned DW   = DefaultDw,
   parameter int unsigned AccW = acc_w(DefaultDim, DefaultDw)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clr_i,
   input  logic                   en_i,
   input  logic signed [DW-1:0]   a_i,
   input  logic signed [DW-1:0]   b_i,
   output logic signed [AccW-1:0] sum_o
);

   logic signed [2*DW-1:0] prod;
   logic signed [AccW-1:0] acc_q, acc_d;

   assign prod  = (2*DW)'(a_i) * (2*DW)'(b_i);
   assign sum_o = acc_q + AccW'(prod);

   // Clear wins over enable so a row's last cycle both writes back and restarts.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = sum_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/vmx_mac_engine.sv
// Matrix-vector multiply core: holds M and x, computes y = M*x one MAC per
// cycle and exposes the results through a registered read port.
module vmx_mac_engine
   import vmx_pkg::*;
#(
   parameter int unsigned DIM = DefaultDim,
   parameter int unsigned DW  = DefaultDw
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic                         wr_en,
   input  logic                         wr_sel,
   input  logic [$clog2(DIM*DIM)-1:0]   wr_addr,
   input  logic [DW-1:0]                wr_data,
   input  logic                         start,
   input  logic                         err_clr,
   input  logic [$clog2(DIM)-1:0]       rd_addr,
   output logic [RES_W-1:0]             rd_data,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int unsigned AddrW = $clog2(DIM*DIM);
   localparam int unsigned IdxW  = $clog2(DIM);
   localparam int unsigned AccW  = acc_w(DIM, DW);

   state_t                state_q, state_d;
   logic [IdxW-1:0]       r_q, r_d, c_q, c_d;
   logic                  err_q, err_d;
   logic [RES_W-1:0]      rd_data_q;
   logic signed [DW-1:0]  mat_q [DIM*DIM];
   logic signed [DW-1:0]  vec_q [DIM];
   logic [RES_W-1:0]      res_q [DIM];

   logic                  mac_clr, mac_en, res_we, wr_ok, viol;
   logic signed [AccW-1:0] mac_sum;
   logic signed [RES_W-1:0] res_ext;

   vmx_mac #(
      .DW   (DW),
      .AccW (AccW)
   ) u_mac (
      .clk_i  (ACLK),
      .rst_ni (ARESETN),
      .clr_i  (mac_clr),
      .en_i   (mac_en),
      .a_i    (mat_q[{r_q, c_q}]),
      .b_i    (vec_q[c_q]),
      .sum_o  (mac_sum)
   );

   assign res_ext = RES_W'(mac_sum);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      res_we  = 1'b0;
      wr_ok   = 1'b0;
      viol    = 1'b0;
      unique case (state_q)
         StRun: begin
            mac_en = 1'b1;
            viol   = wr_en | start;
            if (c_q == IdxW'(DIM - 1)) begin
               res_we  = 1'b1;
               mac_clr = 1'b1;
               c_d     = '0;
               r_d     = r_q + 1'b1;
               if (r_q == IdxW'(DIM - 1)) begin
                  state_d = StDone;
               end
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         default: begin
            // DONE behaves like IDLE for writes and starts; it only lasts a cycle.
            wr_ok   = wr_en;
            state_d = StIdle;
            if (start) begin
               state_d = StRun;
               r_d     = '0;
               c_d     = '0;
               mac_clr = 1'b1;
            end
         end
      endcase
   end

   assign err_d = (err_q & ~err_clr) | viol;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= StIdle;
         r_q     <= '0;
         c_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         err_q   <= err_d;
      end
   end

   // Vector writes beyond DIM-1 are silently dropped.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < DIM*DIM; i++) mat_q[i] <= '0;
         for (int i = 0; i < DIM; i++) vec_q[i] <= '0;
         for (int i = 0; i < DIM; i++) res_q[i] <= '0;
         rd_data_q <= '0;
      end else begin
         if (wr_ok && !wr_sel) begin
            mat_q[wr_addr] <= wr_data;
         end
         if (wr_ok && wr_sel && (wr_addr[AddrW-1:IdxW] == '0)) begin
            vec_q[wr_addr[IdxW-1:0]] <= wr_data;
         end
         if (res_we) begin
            res_q[r_q] <= res_ext;
         end
         rd_data_q <= res_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;
   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign err     = err_q;

endmodule

// File: tb/tb_vmx_mac_engine.sv
// Self-checking bench for vmx_mac_engine: a timing-level reference model
// compared against the DUT every cycle, plus directed literal checks.
module tb_vmx_mac_engine;

   localparam int DIM = 4;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b1;
   logic        wr_en = 1'b0;
   logic        wr_sel = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        start = 1'b0;
   logic        err_clr = 1'b0;
   logic [1:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        busy, done, err;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   bit hold_rd = 1'b0;

   // Reference model state
   int m_mat [DIM*DIM];
   int m_vec [DIM];
   int m_res [DIM];
   int m_k = 0;
   int edge_n = 0;
   bit m_run = 1'b0;
   bit m_err = 1'b0;
   bit exp_busy = 1'b0;
   bit exp_done = 1'b0;
   int exp_rd = 0;

   vmx_mac_engine #(
      .DIM (4),
      .DW  (8)
   ) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .err_clr (err_clr),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dot(input int r);
      int s = 0;
      for (int c = 0; c < DIM; c++) s += m_mat[r*DIM + c] * m_vec[c];
      return s;
   endfunction

   // Model: a start accepted at edge k gives busy after edges k..k+15, done after
   // edge k+16, and row r lands in storage at edge k+(r+1)*DIM.
   initial begin
      for (int i = 0; i < DIM*DIM; i++) m_mat[i] = 0;
      for (int i = 0; i < DIM; i++) begin m_vec[i] = 0; m_res[i] = 0; end
      forever begin
         @(posedge ACLK or negedge ARESETN);
         if (!ARESETN) begin
            for (int i = 0; i < DIM*DIM; i++) m_mat[i] = 0;
            for (int i = 0; i < DIM; i++) begin m_vec[i] = 0; m_res[i] = 0; end
            m_run = 0; m_err = 0; exp_busy = 0; exp_done = 0; exp_rd = 0;
         end else begin
            automatic bit in_run;
            automatic bit v = 0;
            edge_n++;
            in_run = m_run && (edge_n > m_k) && (edge_n <= m_k + DIM*DIM);
            exp_rd = m_res[rd_addr];
            if (in_run) begin
               v = wr_en || start;
               if ((edge_n - m_k) % DIM == 0) m_res[(edge_n - m_k)/DIM - 1] = dot((edge_n - m_k)/DIM - 1);
            end else begin
               if (wr_en && !wr_sel) m_mat[wr_addr] = int'($signed(wr_data));
               if (wr_en && wr_sel && int'(wr_addr) < DIM) m_vec[wr_addr] = int'($signed(wr_data));
               if (start) begin m_run = 1; m_k = edge_n; end
            end
            m_err = (m_err && !err_clr) || v;
            exp_busy = m_run && (edge_n >= m_k) && (edge_n < m_k + DIM*DIM);
            exp_done = m_run && (edge_n == m_k + DIM*DIM);
         end
      end
   end

   initial forever begin
      @(negedge ACLK);
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("done", 32'(done), 32'(exp_done));
         chk("err", 32'(err), 32'(m_err));
         chk("rd_data", rd_data, 32'(exp_rd));
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
      if (!hold_rd) rd_addr = 2'($urandom_range(0, 3));
   endtask

   task automatic wr(input bit sel, input int addr, input int data);
      wr_en = 1; wr_sel = sel; wr_addr = 4'(addr); wr_data = 8'(data);
      tick();
      wr_en = 0;
   endtask

   task automatic rd(input int a, input int exp, input string name);
      hold_rd = 1;
      rd_addr = 2'(a);
      @(posedge ACLK);
      #1;
      chk(name, rd_data, 32'(exp));
      hold_rd = 0;
   endtask

   task automatic load_random();
      for (int i = 0; i < DIM*DIM; i++) wr(0, i, int'($urandom_range(0, 255)));
      for (int i = 0; i < DIM; i++) wr(1, i, int'($urandom_range(0, 255)));
   endtask

   task automatic wait_done(input bit inject, input int lat0);
      int lat = lat0;
      while (!done && lat < 40) begin
         if (inject) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_sel  = 1'($urandom);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 8'($urandom_range(0, 255));
            start   = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
         end
         tick();
         lat++;
         wr_en = 0; start = 0; err_clr = 0;
      end
      chk("latency", 32'(lat), 32'd17);
   endtask

   task automatic run(input bit inject);
      start = 1;
      tick();
      start = 0;
      wait_done(inject, 1);
   endtask

   initial begin
      int exp_r [DIM];
      #2 ARESETN = 0;
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1;
      chk_en = 1;
      repeat (10) tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_err", 32'(err), 32'd0);

      // Identity matrix times [1,2,3,4]
      for (int i = 0; i < DIM*DIM; i++) wr(0, i, (i / DIM == i % DIM) ? 1 : 0);
      for (int i = 0; i < DIM; i++) wr(1, i, i + 1);
      run(0);
      for (int i = 0; i < DIM; i++) begin
         chk("model_ident", 32'(m_res[i]), 32'(i + 1));
         rd(i, i + 1, "ident_rd");
      end

      // Extreme operands
      for (int i = 0; i < DIM*DIM; i++) wr(0, i, 8'h80);
      for (int i = 0; i < DIM; i++) wr(1, i, 8'h80);
      run(0);
      for (int i = 0; i < DIM; i++) rd(i, 32'h0001_0000, "neg_neg_rd");
      for (int i = 0; i < DIM*DIM; i++) wr(0, i, 127);
      run(0);
      for (int i = 0; i < DIM; i++) begin
         chk("model_mix", 32'(m_res[i]), 32'hFFFF_0200);
         rd(i, 32'hFFFF_0200, "pos_neg_rd");
      end

      // Protocol violations during a run leave the results untouched
      load_random();
      for (int i = 0; i < DIM; i++) exp_r[i] = dot(i);
      start = 1; tick(); start = 0;
      repeat (3) tick();
      start = 1; wr_en = 1; wr_sel = 0; wr_addr = 4'd5; wr_data = 8'd99;
      tick();
      start = 0; wr_en = 0;
      chk("err_set", 32'(err), 32'd1);
      wait_done(0, 5);
      for (int i = 0; i < DIM; i++) rd(i, exp_r[i], "undisturbed_rd");
      chk("err_sticky", 32'(err), 32'd1);
      err_clr = 1; tick(); err_clr = 0;
      chk("err_clr", 32'(err), 32'd0);

      // Reset in the middle of a run
      load_random();
      start = 1; tick(); start = 0;
      repeat (7) tick();
      ARESETN = 0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      repeat (2) tick();
      ARESETN = 1;
      for (int i = 0; i < DIM; i++) rd(i, 0, "rst_rd");
      load_random();
      for (int i = 0; i < DIM; i++) exp_r[i] = dot(i);
      run(0);
      for (int i = 0; i < DIM; i++) rd(i, exp_r[i], "rerun_rd");

      // Start accepted in the DONE cycle
      run(0);
      start = 1; tick(); start = 0;
      chk("done_restart_busy", 32'(busy), 32'd1);
      wait_done(0, 1);

      // Randomized runs with stray writes and violations
      for (int it = 0; it < 8; it++) begin
         repeat ($urandom_range(4, 20)) begin
            if ($urandom_range(0, 1) == 1) wr(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            else wr(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
         end
         run(1);
         for (int i = 0; i < DIM; i++) rd(i, dot(i), "rand_rd");
         if ($urandom_range(0, 1) == 1) begin err_clr = 1; tick(); err_clr = 0; end
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
